// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, DR selector and opcode helpers.
`timescale 1ns/1ps
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'h0,
    RunTestIdle    = 4'h1,
    SelectDRScan   = 4'h2,
    CaptureDR      = 4'h3,
    ShiftDR        = 4'h4,
    Exit1DR        = 4'h5,
    PauseDR        = 4'h6,
    Exit2DR        = 4'h7,
    UpdateDR       = 4'h8,
    SelectIRScan   = 4'h9,
    CaptureIR      = 4'hA,
    ShiftIR        = 4'hB,
    Exit1IR        = 4'hC,
    PauseIR        = 4'hD,
    Exit2IR        = 4'hE,
    UpdateIR       = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  localparam int unsigned IDCODE_WIDTH = 32;

  // All-ones opcode of the given IR width.
  function automatic logic [31:0] op_bypass(input int unsigned ir_width);
    return (ir_width >= 32) ? '1 : ((32'd1 << ir_width) - 32'd1);
  endfunction

  function automatic logic [31:0] op_idcode(input int unsigned ir_width);
    return 32'd1 & op_bypass(ir_width);
  endfunction

  function automatic logic [31:0] op_user(input int unsigned ir_width, input int unsigned k);
    return (32'd2 + 32'(k)) & op_bypass(ir_width);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register and tms-driven next state.
`timescale 1ns/1ps
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_nxt;

  // State register, asynchronously forced to TestLogicReset by trst.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TestLogicReset;
    else       state <= state_nxt;
  end

  // Standard TAP transitions selected by tms.
  always_comb begin
    state_nxt = state;
    unique case (state)
      TestLogicReset: state_nxt = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_nxt = tms ? SelectDRScan   : RunTestIdle;
      SelectDRScan:   state_nxt = tms ? SelectIRScan   : CaptureDR;
      CaptureDR:      state_nxt = tms ? Exit1DR        : ShiftDR;
      ShiftDR:        state_nxt = tms ? Exit1DR        : ShiftDR;
      Exit1DR:        state_nxt = tms ? UpdateDR       : PauseDR;
      PauseDR:        state_nxt = tms ? Exit2DR        : PauseDR;
      Exit2DR:        state_nxt = tms ? UpdateDR       : ShiftDR;
      UpdateDR:       state_nxt = tms ? SelectDRScan   : RunTestIdle;
      SelectIRScan:   state_nxt = tms ? TestLogicReset : CaptureIR;
      CaptureIR:      state_nxt = tms ? Exit1IR        : ShiftIR;
      ShiftIR:        state_nxt = tms ? Exit1IR        : ShiftIR;
      Exit1IR:        state_nxt = tms ? UpdateIR       : PauseIR;
      PauseIR:        state_nxt = tms ? Exit2IR        : PauseIR;
      Exit2IR:        state_nxt = tms ? UpdateIR       : ShiftIR;
      UpdateIR:       state_nxt = tms ? SelectDRScan   : RunTestIdle;
    endcase
  end

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP: IR, BYPASS, IDCODE and NUM_USER user data registers.
`timescale 1ns/1ps
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
  parameter int unsigned NUM_USER      = 2,
  parameter int unsigned USER_DR_WIDTH = 8
) (
  input  logic                              tck,
  input  logic                              trst,
  input  logic                              tms,
  input  logic                              tdi,
  output logic                              tdo,
  output logic                              tdo_en,
  output logic [3:0]                        state,
  output logic [IR_WIDTH-1:0]               ir,
  input  logic [NUM_USER*USER_DR_WIDTH-1:0] user_capture,
  output logic [NUM_USER*USER_DR_WIDTH-1:0] user_update,
  output logic [NUM_USER-1:0]               user_update_stb
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(op_bypass(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(op_idcode(IR_WIDTH));

  tap_state_t                st;
  logic [IR_WIDTH-1:0]       ir_sr;
  logic                      bypass_sr;
  logic [IDCODE_WIDTH-1:0]   idcode_sr;
  logic [USER_DR_WIDTH-1:0]  user_sr      [NUM_USER];
  logic [USER_DR_WIDTH-1:0]  user_shifted [NUM_USER];
  dr_sel_t                   dr_sel;
  logic [NUM_USER-1:0]       user_hit;
  logic                      dr_lsb;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (st)
  );

  assign state = st;

  // Decode the latched instruction; all-ones and unknown opcodes fall to BYPASS.
  always_comb begin
    dr_sel   = DR_BYPASS;
    user_hit = '0;
    if (ir == OP_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir != OP_BYPASS) begin
      for (int unsigned k = 0; k < NUM_USER; k++) begin
        if (ir == IR_WIDTH'(op_user(IR_WIDTH, k))) begin
          dr_sel      = DR_USER;
          user_hit[k] = 1'b1;
        end
      end
    end
  end

  // Instruction shift register: capture 01, shift right with tdi at the MSB.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                ir_sr <= '0;
    else if (st == CaptureIR) ir_sr <= IR_WIDTH'(2'b01);
    else if (st == ShiftIR)   ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
  end

  // Latched instruction, back to IDCODE whenever the TAP sits in TestLogicReset.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                     ir <= OP_IDCODE;
    else if (st == TestLogicReset) ir <= OP_IDCODE;
    else if (st == UpdateIR)       ir <= ir_sr;
  end

  // Single-bit bypass register.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) bypass_sr <= 1'b0;
    else if (dr_sel == DR_BYPASS) begin
      if (st == CaptureDR)    bypass_sr <= 1'b0;
      else if (st == ShiftDR) bypass_sr <= tdi;
    end
  end

  // IDCODE register.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) idcode_sr <= '0;
    else if (dr_sel == DR_IDCODE) begin
      if (st == CaptureDR)    idcode_sr <= IDCODE_VAL;
      else if (st == ShiftDR) idcode_sr <= {tdi, idcode_sr[IDCODE_WIDTH-1:1]};
    end
  end

  // Right-shifted user register images; written so a 1-bit register also works.
  always_comb begin
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      user_shifted[k]                  = user_sr[k] >> 1;
      user_shifted[k][USER_DR_WIDTH-1] = tdi;
    end
  end

  // User shift registers: capture from the core, shift when selected.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      for (int unsigned k = 0; k < NUM_USER; k++) user_sr[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_USER; k++) begin
        if (user_hit[k]) begin
          if (st == CaptureDR)
            user_sr[k] <= user_capture[k*USER_DR_WIDTH +: USER_DR_WIDTH];
          else if (st == ShiftDR)
            user_sr[k] <= user_shifted[k];
        end
      end
    end
  end

  // Update latches and one-cycle strobe for the selected user register.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      user_update     <= '0;
      user_update_stb <= '0;
    end else begin
      user_update_stb <= '0;
      for (int unsigned k = 0; k < NUM_USER; k++) begin
        if (st == UpdateDR && user_hit[k]) begin
          user_update[k*USER_DR_WIDTH +: USER_DR_WIDTH] <= user_sr[k];
          user_update_stb[k]                            <= 1'b1;
        end
      end
    end
  end

  // LSB of the active data register.
  always_comb begin
    dr_lsb = bypass_sr;
    if (dr_sel == DR_IDCODE) dr_lsb = idcode_sr[0];
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (user_hit[k]) dr_lsb = user_sr[k][0];
    end
  end

  // tdo/tdo_en change on the falling edge, driven only in the Shift states.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (st == ShiftIR) begin
      tdo    <= ir_sr[0];
      tdo_en <= 1'b1;
    end else if (st == ShiftDR) begin
      tdo    <= dr_lsb;
      tdo_en <= 1'b1;
    end else begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end
  end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
Parametrised IEEE 1149.1 TAP controller. It is the next generation of the team's fixed `jtag` block.
- Full 16-state TAP FSM with configurable instruction register (IR) width.
- Data registers: BYPASS, IDCODE and NUM_USER user data registers of configurable width.
- Each user register has parallel capture/update ports into the core.
- Sits between the chip-level JTAG pins and on-chip debug/config logic.

Parameters:
IR_WIDTH, 4, instruction register length in bits (>=2).
IDCODE_VAL, 32'h1000_0001, value shifted out by IDCODE; bit 0 must be 1.
NUM_USER, 2, number of user data registers (1..4).
USER_DR_WIDTH, 8, length of each user data register in bits (>=1).

Ports:
tck  input  1  JTAG test clock; the only clock.
trst  input  1  asynchronous active-low reset.
tms  input  1  test mode select, sampled on posedge tck.
tdi  input  1  test data in, sampled on posedge tck.
tdo  output  1  test data out, changes on negedge tck.
tdo_en  output  1  high while in ShiftIR or ShiftDR, registered on negedge tck.
state  output  4  current TAP state encoding from jtag_pkg.
ir  output  IR_WIDTH  current latched instruction.
user_capture  input  NUM_USER*USER_DR_WIDTH  parallel values loaded in CaptureDR; slice k belongs to user register k.
user_update  output  NUM_USER*USER_DR_WIDTH  update latches, loaded in UpdateDR.
user_update_stb  output  NUM_USER  one-tck pulse when user register k is updated.

Behaviour:
- Reset: trst low forces the following asynchronously, regardless of tck:
  - state=TestLogicReset, ir=IDCODE opcode.
  - IR shift register=0, DR shift registers=0.
  - user_update=0, user_update_stb=0, tdo=0, tdo_en=0.
- Reset mid-shift discards the partial shift with no update.
- Synchronous reset: five consecutive tck with tms=1 reach TestLogicReset from any state. Entering TestLogicReset reloads ir=IDCODE opcode.
- FSM: all 16 standard states with standard tms transitions, updated on posedge tck. TestLogicReset with tms=0 goes to RunTestIdle.
- Opcodes (IR_WIDTH wide):
  - all-ones = BYPASS.
  - 1 = IDCODE.
  - 2+k = USER k, for k < NUM_USER.
  - Any other opcode selects BYPASS.
- CaptureIR: IR shift register loads {0..., 2'b01}.
- ShiftIR: shifts right (tdi in at MSB, LSB out), one bit per tck.
- UpdateIR: ir <= IR shift register on posedge tck.
- CaptureDR loads the DR selected by ir:
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VAL.
  - USER k loads slice k of user_capture.
- ShiftDR: selected DR shifts right, LSB first.
- UpdateDR for USER k:
  - user_update slice k <= shift register on posedge tck.
  - user_update_stb[k]=1 for exactly that one cycle.
  - Other slices hold their values.
- UpdateDR for BYPASS or IDCODE has no side effect.
- tdo:
  - On negedge tck, tdo <= LSB of the active shift register while in ShiftIR/ShiftDR.
  - Otherwise tdo <= 0 and tdo_en <= 0.
  - Result: the first bit appears half a cycle after entering the Shift state.
- Pausing: Exit1/Pause/Exit2 hold the shift contents. Exit2 -> Shift resumes from the preserved position.
- ir changes only in UpdateIR or TestLogicReset. A DR shift uses the ir latched at CaptureDR.

Decomposition:
- Package jtag_pkg (shared with the existing jtag block and its formal harness):
  - tap_state_t enum with 4-bit encodings: TestLogicReset, RunTestIdle, SelectDRScan, CaptureDR, ShiftDR, Exit1DR, PauseDR, Exit2DR, UpdateDR, SelectIRScan, CaptureIR, ShiftIR, Exit1IR, PauseIR, Exit2IR, UpdateIR.
  - Opcode constant functions for BYPASS, IDCODE and USER(k), parametrised by IR_WIDTH.
- One sub-module, jtag_tap_fsm: the state register plus next-state logic (tck, trst, tms in; state out). It is reused by the formal harness.

Test Plan:
- trst low pulse mid-ShiftDR -> immediately state=TestLogicReset, ir=4'b0001, tdo=0, user_update unchanged at 0, no strobe.
- From RunTestIdle, tms=1,1,1,1,1 -> state=TestLogicReset on 5th posedge; also from ShiftIR, PauseDR and UpdateIR.
- After reset, go to ShiftDR and shift 32 bits -> tdo sequence LSB-first equals 32'h1000_0001.
- Load IR=4'b0010 (USER0); capture with user_capture[7:0]=8'hA5; shift in 8'h3C -> tdo outputs A5 LSB-first; user_update[7:0]=8'h3C; user_update_stb=2'b01 for one cycle; user_update[15:8] unchanged.
- Load IR=4'b1111 -> DR path is one bit: shift 1,0,1,1 -> tdo lags tdi by one bit (0,1,0,1). Opcode 4'b0111 behaves identically.
- ShiftIR readback -> first two bits out are 1,0 (capture pattern 01). ShiftDR with USER1 interrupted by PauseDR for 3 cycles, then resumed -> final update equals the uninterrupted result.
